// File: rtl/sv39_ptw_pkg.sv
// Shared Sv39 walker definitions: PTE bit positions, satp modes,
// walker state encoding and the PTE check result bundle.
package sv39_ptw_pkg;

    localparam int PTE_V       = 0;
    localparam int PTE_R       = 1;
    localparam int PTE_W       = 2;
    localparam int PTE_X       = 3;
    localparam int PTE_U       = 4;
    localparam int PTE_G       = 5;
    localparam int PTE_A       = 6;
    localparam int PTE_D       = 7;
    localparam int PTE_PPN_LSB = 10;
    localparam int PTE_PPN_MSB = 53;

    localparam logic [3:0] SATP_MODE_BARE = 4'd0;
    localparam logic [3:0] SATP_MODE_SV39 = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEMREQ,
        S_MEMWAIT,
        S_RESP,
        S_DRAIN
    } ptw_state_t;

    typedef struct packed {
        logic        leaf;
        logic        pf;
        logic [43:0] ppn;
    } pte_check_t;

endpackage

// File: rtl/sv39_pte_check.sv
// Combinational Sv39 PTE evaluation: leaf detection, page-fault
// conditions and superpage PPN merge with the virtual page number.
module sv39_pte_check
    import sv39_ptw_pkg::*;
(
    input  logic [63:0] pte_i,
    input  logic [1:0]  level_i,
    input  logic        store_i,
    input  logic [17:0] vpn_lo_i,
    output logic        leaf_o,
    output logic        pf_o,
    output logic [43:0] ppn_o
);

    logic [43:0] ppn;
    logic        invalid;
    logic        is_leaf;
    logic        misalign;
    logic        leaf_fault;
    logic        unused;

    assign ppn    = pte_i[PTE_PPN_MSB:PTE_PPN_LSB];
    assign unused = ^{pte_i[9:8], pte_i[PTE_G], pte_i[PTE_U]};

    always_comb begin
        misalign = 1'b0;
        ppn_o    = ppn;
        unique case (level_i)
            2'd2: begin
                misalign = (ppn[17:0] != '0);
                ppn_o    = {ppn[43:18], vpn_lo_i};
            end
            2'd1: begin
                misalign = (ppn[8:0] != '0);
                ppn_o    = {ppn[43:9], vpn_lo_i[8:0]};
            end
            default: begin
                misalign = 1'b0;
                ppn_o    = ppn;
            end
        endcase

        invalid = !pte_i[PTE_V]
               || (!pte_i[PTE_R] && pte_i[PTE_W])
               || (pte_i[63:54] != '0);
        is_leaf = pte_i[PTE_R] || pte_i[PTE_X];

        // A/D are never updated in hardware, so a clear bit must fault
        leaf_fault = misalign
                  || !pte_i[PTE_A]
                  || (store_i && !pte_i[PTE_D]);

        leaf_o = !invalid && is_leaf;
        pf_o   = invalid
              || (is_leaf ? leaf_fault : (level_i == 2'd0));
    end

endmodule

// File: rtl/sv39_ptw.sv
// Sv39 page-table walker: one PTE read in flight on a 64-bit port,
// returns a leaf translation or fault to the requesting TLB.
module sv39_ptw
    import sv39_ptw_pkg::*;
#(
    parameter int PADDR_W = 56,
    parameter int VADDR_W = 64
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic [63:0]        satp_i,
    input  logic               flush_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [VADDR_W-1:0] req_vaddr_i,
    input  logic               req_store_i,
    output logic               mem_req_valid_o,
    input  logic               mem_req_ready_i,
    output logic [PADDR_W-1:0] mem_req_addr_o,
    input  logic               mem_resp_valid_i,
    input  logic [63:0]        mem_resp_data_i,
    input  logic               mem_resp_err_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [43:0]        resp_ppn_o,
    output logic [1:0]         resp_level_o,
    output logic [7:0]         resp_flags_o,
    output logic               resp_pf_o,
    output logic               resp_af_o
);

    ptw_state_t  state_q, state_d;
    logic [26:0] vpn_q, vpn_d;
    logic        store_q, store_d;
    logic [43:0] base_q, base_d;
    logic [1:0]  level_q, level_d;
    logic [43:0] ppn_q, ppn_d;
    logic [7:0]  flags_q, flags_d;
    logic        pf_q, pf_d;
    logic        af_q, af_d;

    logic [8:0]  vpn_sel;
    logic        noncanon;
    pte_check_t  chk;
    logic        unused;

    assign unused = ^{req_vaddr_i[11:0], satp_i[59:44]};

    sv39_pte_check u_check (
        .pte_i    (mem_resp_data_i),
        .level_i  (level_q),
        .store_i  (store_q),
        .vpn_lo_i (vpn_q[17:0]),
        .leaf_o   (chk.leaf),
        .pf_o     (chk.pf),
        .ppn_o    (chk.ppn)
    );

    always_comb begin
        unique case (level_q)
            2'd2:    vpn_sel = vpn_q[26:18];
            2'd1:    vpn_sel = vpn_q[17:9];
            default: vpn_sel = vpn_q[8:0];
        endcase
    end

    assign mem_req_addr_o = PADDR_W'({base_q, 12'h000} + 56'({vpn_sel, 3'b000}));
    assign noncanon = (req_vaddr_i[VADDR_W-1:39] != {(VADDR_W-39){req_vaddr_i[38]}});

    assign resp_ppn_o   = ppn_q;
    assign resp_level_o = level_q;
    assign resp_flags_o = flags_q;
    assign resp_pf_o    = pf_q;
    assign resp_af_o    = af_q;

    always_comb begin
        state_d         = state_q;
        vpn_d           = vpn_q;
        store_d         = store_q;
        base_d          = base_q;
        level_d         = level_q;
        ppn_d           = ppn_q;
        flags_d         = flags_q;
        pf_d            = pf_q;
        af_d            = af_q;
        req_ready_o     = 1'b0;
        mem_req_valid_o = 1'b0;
        resp_valid_o    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                req_ready_o = !flush_i;
                if (req_valid_i && !flush_i) begin
                    vpn_d   = req_vaddr_i[38:12];
                    store_d = req_store_i;
                    base_d  = satp_i[43:0];
                    level_d = 2'd2;
                    ppn_d   = '0;
                    flags_d = '0;
                    pf_d    = 1'b0;
                    af_d    = 1'b0;
                    if (satp_i[63:60] == SATP_MODE_BARE) begin
                        state_d = S_RESP;
                        ppn_d   = req_vaddr_i[55:12];
                        level_d = 2'd0;
                        flags_d = 8'hCF;
                    end else if (noncanon) begin
                        state_d = S_RESP;
                        pf_d    = 1'b1;
                    end else begin
                        state_d = S_MEMREQ;
                    end
                end
            end
            S_MEMREQ: begin
                // Withhold valid under flush so no orphan read is issued
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    mem_req_valid_o = 1'b1;
                    if (mem_req_ready_i) state_d = S_MEMWAIT;
                end
            end
            S_MEMWAIT: begin
                if (mem_resp_valid_i) begin
                    if (flush_i) begin
                        state_d = S_IDLE;
                    end else if (mem_resp_err_i) begin
                        state_d = S_RESP;
                        af_d    = 1'b1;
                    end else if (chk.pf) begin
                        state_d = S_RESP;
                        pf_d    = 1'b1;
                    end else if (chk.leaf) begin
                        state_d = S_RESP;
                        ppn_d   = chk.ppn;
                        flags_d = mem_resp_data_i[7:0];
                    end else begin
                        state_d = S_MEMREQ;
                        base_d  = mem_resp_data_i[PTE_PPN_MSB:PTE_PPN_LSB];
                        level_d = level_q - 2'd1;
                    end
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_RESP: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    resp_valid_o = 1'b1;
                    if (resp_ready_i) state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mem_resp_valid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q <= S_IDLE;
            vpn_q   <= '0;
            store_q <= 1'b0;
            base_q  <= '0;
            level_q <= '0;
            ppn_q   <= '0;
            flags_q <= '0;
            pf_q    <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vpn_q   <= vpn_d;
            store_q <= store_d;
            base_q  <= base_d;
            level_q <= level_d;
            ppn_q   <= ppn_d;
            flags_q <= flags_d;
            pf_q    <= pf_d;
            af_q    <= af_d;
        end
    end

endmodule

// File: doc/sv39_ptw.md
Name: sv39_ptw

Overview:
Sv39 hardware page-table walker. It consumes the live satp value and walks the three-level page table through a single 64-bit memory read port. It sits between the I/D TLB miss logic (request side) and the cache/bus read path (memory side). It returns a leaf PTE or a fault to the requesting TLB.

Parameters:
PADDR_W, 56, physical address width of the memory request
VADDR_W, 64, width of the virtual address input

Ports:
clk_i  in  1  clock
arst_i  in  1  reset, synchronous, active-high
satp_i  in  64  current satp {mode[63:60], 16'b0, ppn[43:0]}
flush_i  in  1  sfence.vma / satp change; aborts any walk
req_valid_i  in  1  TLB miss request valid
req_ready_o  out  1  walker idle and able to accept
req_vaddr_i  in  64  faulting virtual address
req_store_i  in  1  access is a store (D-bit check)
mem_req_valid_o  out  1  PTE read request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  56  PTE physical address, 8-byte aligned
mem_resp_valid_i  in  1  read data valid
mem_resp_data_i  in  64  PTE
mem_resp_err_i  in  1  bus error on PTE read
resp_valid_o  out  1  walk result valid
resp_ready_i  in  1  TLB consumes result
resp_ppn_o  out  44  leaf PPN (bare: vaddr[55:12])
resp_level_o  out  2  leaf level (2=1GiB, 1=2MiB, 0=4KiB)
resp_flags_o  out  8  leaf PTE[7:0] (D A G U X W R V)
resp_pf_o  out  1  page fault
resp_af_o  out  1  access fault (bus error)

Behaviour:
- Reset: state IDLE; req_ready_o=1; mem_req_valid_o=0; resp_valid_o=0; all resp_* data outputs 0.
- FSM states: IDLE, MEMREQ, MEMWAIT, RESP, DRAIN.
- IDLE: req_ready_o=1. On req_valid_i, latch vaddr, store, satp.ppn and satp.mode; set level=2.
  - Mode BARE: go to RESP with ppn=vaddr[55:12], level=0, flags=8'hCF, pf=0.
  - Mode SV39 with vaddr[63:39] != {25{vaddr[38]}}: go to RESP with pf=1.
  - Otherwise go to MEMREQ.
- MEMREQ: mem_req_valid_o=1; addr = {base_ppn,12'b0} + {vpn[level],3'b0}. base_ppn is satp.ppn at level 2, else the previous PTE[53:10]. Hold addr stable until mem_req_ready_i; then go to MEMWAIT.
- MEMWAIT: on mem_resp_valid_i, evaluate:
  - err: RESP with af=1.
  - V=0, or (R=0 & W=1), or PTE[63:54]!=0: RESP with pf=1.
  - Leaf (R|X): pf=1 if level>0 and the low PPN fields are not 0 (level1: ppn[8:0]; level2: ppn[17:0]). pf=1 if A=0. pf=1 if store & D=0. Otherwise RESP with a successful leaf.
  - Non-leaf at level 0: pf=1. Otherwise level-1 and go to MEMREQ.
  - Hardware never updates A/D bits.
- Leaf ppn output for superpages: ppn low fields replaced by the matching vpn fields.
- RESP: resp_valid_o held high with data stable until resp_ready_i; then go to IDLE.
- Latency: request accept to first mem_req_valid_o is 1 cycle. Memory response to next request is 1 cycle. Memory response to resp_valid_o is 1 cycle. Bare-mode result is 1 cycle after accept.
- flush_i handling:
  - In MEMREQ (request not yet accepted) or RESP: go to IDLE; no response is issued.
  - In MEMWAIT: go to DRAIN. DRAIN waits for mem_resp_valid_i, discards the data, then goes to IDLE.
  - In IDLE: flush_i has priority, and a request arriving in that same cycle is not accepted (req_ready_o=0 while flush_i=1).
- satp_i changes mid-walk have no effect on the walk; the latched copy is used. Software pairs satp writes with a flush.
- Reset mid-walk: FSM returns to IDLE immediately. Any outstanding memory response is ignored by the memory side's own reset.

Decomposition:
- Shared package gets: Sv39 PTE bit positions (V,R,W,X,U,G,A,D, PPN[53:10]), satp mode encodings (BARE=0, SV39=8), the ptw_state_t enum, and a pte_check_t result struct.
- One combinational sub-module, sv39_pte_check: takes PTE, level and store; returns leaf, fault and the merged ppn.

Test Plan:
- BARE: satp=0, vaddr=0x0000_0080_1234_5678 -> resp in 1 cycle, ppn=0x8012345, pf=0, no mem_req.
- 3-level 4K walk: satp={8,ppn=0x80000}. Mem returns non-leaf 0x20000401, then 0x20000801, then leaf 0x200010CF -> 3 requests; first addr=0x80000000+vpn2*8; resp ppn=0x80004, level=0.
- 2MiB superpage: level-1 leaf with ppn[8:0]=0 -> level=1, ppn[8:0]=vaddr[20:12]. Same case with ppn[8:0]=1 -> pf=1.
- Faults: non-canonical vaddr 0x0000_0100_0000_0000 -> pf with no mem_req. V=0 PTE -> pf. Store to PTE with D=0 -> pf. mem_resp_err_i -> af=1.
- Flush during MEMWAIT: flush_i pulses, response arrives 3 cycles later -> no resp_valid_o; req_ready_o returns 1 the cycle after the drained response.
- Backpressure: mem_req_ready_i low 4 cycles -> addr stable. resp_ready_i low 3 cycles -> resp_* stable, no new req accepted.
